// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched ops until both operands are valid,
// snoops two result buses for wakeup, and issues the lowest ready entry per cycle.

`ifndef dataWidth
`define dataWidth 32
`endif
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef newopWidth
`define newopWidth 6
`endif
`ifndef tagWidth
`define tagWidth 5
`endif
`ifndef tagFree
`define tagFree 5'd0
`endif

module rs_alu #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   alloc_en,
  input  logic [`newopWidth-1:0] alloc_op,
  input  logic [`addrWidth-1:0]  alloc_pc,
  input  logic [`tagWidth-1:0]   alloc_dest,
  input  logic [`dataWidth-1:0]  alloc_v1,
  input  logic [`dataWidth-1:0]  alloc_v2,
  input  logic [`tagWidth-1:0]   alloc_q1,
  input  logic [`tagWidth-1:0]   alloc_q2,
  input  logic                   cdb0_en,
  input  logic [`tagWidth-1:0]   cdb0_tag,
  input  logic [`dataWidth-1:0]  cdb0_data,
  input  logic                   cdb1_en,
  input  logic [`tagWidth-1:0]   cdb1_tag,
  input  logic [`dataWidth-1:0]  cdb1_data,
  output logic                   full,
  output logic                   ex_alu_en,
  output logic [`dataWidth-1:0]  exsrc1,
  output logic [`dataWidth-1:0]  exsrc2,
  output logic [`addrWidth-1:0]  expc,
  output logic [`newopWidth-1:0] exaluop,
  output logic [`tagWidth-1:0]   exdest
);

  localparam int unsigned DW = `dataWidth;
  localparam int unsigned AW = `addrWidth;
  localparam int unsigned OW = `newopWidth;
  localparam int unsigned TW = `tagWidth;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [TW-1:0] TAG_FREE = `tagFree;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [AW-1:0] pc;
    logic [TW-1:0] dest;
    logic [DW-1:0] v1;
    logic [TW-1:0] q1;
    logic [DW-1:0] v2;
    logic [TW-1:0] q2;
  } entry_t;

  logic [DEPTH-1:0] busy;
  entry_t           ent [DEPTH];

  logic [DEPTH-1:0] ready_c;
  logic             ready_found_c;
  logic [IW-1:0]    ready_idx_c;
  logic [IW-1:0]    free_idx_c;
  logic             alloc_go_c;
  logic [DW-1:0]    a_v1_c;
  logic [DW-1:0]    a_v2_c;
  logic [TW-1:0]    a_q1_c;
  logic [TW-1:0]    a_q2_c;

  // A pending tag is satisfied by a bus only if the tag is a real producer tag.
  function automatic logic tag_hit(input logic en, input logic [TW-1:0] bus_tag,
                                   input logic [TW-1:0] q);
    return en && (bus_tag == q) && (q != TAG_FREE);
  endfunction

  assign full       = &busy;
  assign alloc_go_c = alloc_en && !full && !clr;

  // Lowest-index free and ready entries; iterating downward lets the lowest win.
  always_comb begin
    ready_c     = '0;
    ready_idx_c = '0;
    free_idx_c  = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      ready_c[i] = busy[i] && (ent[i].q1 == TAG_FREE) && (ent[i].q2 == TAG_FREE);
      if (ready_c[i]) ready_idx_c = IW'(i);
      if (!busy[i])   free_idx_c  = IW'(i);
    end
    ready_found_c = |ready_c;
  end

  // Same-cycle bypass of incoming operands from the result buses; cdb0 has priority.
  always_comb begin
    a_v1_c = alloc_v1;
    a_q1_c = alloc_q1;
    a_v2_c = alloc_v2;
    a_q2_c = alloc_q2;
    if (tag_hit(cdb0_en, cdb0_tag, alloc_q1)) begin
      a_v1_c = cdb0_data;
      a_q1_c = TAG_FREE;
    end else if (tag_hit(cdb1_en, cdb1_tag, alloc_q1)) begin
      a_v1_c = cdb1_data;
      a_q1_c = TAG_FREE;
    end
    if (tag_hit(cdb0_en, cdb0_tag, alloc_q2)) begin
      a_v2_c = cdb0_data;
      a_q2_c = TAG_FREE;
    end else if (tag_hit(cdb1_en, cdb1_tag, alloc_q2)) begin
      a_v2_c = cdb1_data;
      a_q2_c = TAG_FREE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      ex_alu_en <= 1'b0;
      exsrc1    <= '0;
      exsrc2    <= '0;
      expc      <= '0;
      exaluop   <= '0;
      exdest    <= TAG_FREE;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ent[i] <= '{op: '0, pc: '0, dest: TAG_FREE, v1: '0, q1: TAG_FREE, v2: '0, q2: TAG_FREE};
      end
    end else if (clr) begin
      busy      <= '0;
      ex_alu_en <= 1'b0;
    end else begin
      // Wakeup of waiting operands in busy entries.
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (busy[i]) begin
          if (tag_hit(cdb0_en, cdb0_tag, ent[i].q1)) begin
            ent[i].v1 <= cdb0_data;
            ent[i].q1 <= TAG_FREE;
          end else if (tag_hit(cdb1_en, cdb1_tag, ent[i].q1)) begin
            ent[i].v1 <= cdb1_data;
            ent[i].q1 <= TAG_FREE;
          end
          if (tag_hit(cdb0_en, cdb0_tag, ent[i].q2)) begin
            ent[i].v2 <= cdb0_data;
            ent[i].q2 <= TAG_FREE;
          end else if (tag_hit(cdb1_en, cdb1_tag, ent[i].q2)) begin
            ent[i].v2 <= cdb1_data;
            ent[i].q2 <= TAG_FREE;
          end
        end
      end

      ex_alu_en <= ready_found_c;
      if (ready_found_c) begin
        busy[ready_idx_c] <= 1'b0;
        exsrc1  <= ent[ready_idx_c].v1;
        exsrc2  <= ent[ready_idx_c].v2;
        expc    <= ent[ready_idx_c].pc;
        exaluop <= ent[ready_idx_c].op;
        exdest  <= ent[ready_idx_c].dest;
      end

      // The free slot was non-busy pre-edge, so it never collides with the issued one.
      if (alloc_go_c) begin
        busy[free_idx_c] <= 1'b1;
        ent[free_idx_c]  <= '{op: alloc_op, pc: alloc_pc, dest: alloc_dest,
                              v1: a_v1_c, q1: a_q1_c, v2: a_v2_c, q2: a_q2_c};
      end
    end
  end

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu: stimulus pushes expected issues into a queue and a
// negedge monitor pops and compares every ex_alu_en pulse.

`ifndef dataWidth
`define dataWidth 32
`endif
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef newopWidth
`define newopWidth 6
`endif
`ifndef tagWidth
`define tagWidth 5
`endif
`ifndef tagFree
`define tagFree 5'd0
`endif

module tb_rs_alu;

  localparam int unsigned DW = `dataWidth;
  localparam int unsigned AW = `addrWidth;
  localparam int unsigned OW = `newopWidth;
  localparam int unsigned TW = `tagWidth;
  localparam logic [TW-1:0] TF = `tagFree;

  typedef struct packed {
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic [AW-1:0] pc;
    logic [OW-1:0] op;
    logic [TW-1:0] dest;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          alloc_en;
  logic [OW-1:0] alloc_op;
  logic [AW-1:0] alloc_pc;
  logic [TW-1:0] alloc_dest;
  logic [DW-1:0] alloc_v1, alloc_v2;
  logic [TW-1:0] alloc_q1, alloc_q2;
  logic          cdb0_en, cdb1_en;
  logic [TW-1:0] cdb0_tag, cdb1_tag;
  logic [DW-1:0] cdb0_data, cdb1_data;
  logic          full, ex_alu_en;
  logic [DW-1:0] exsrc1, exsrc2;
  logic [AW-1:0] expc;
  logic [OW-1:0] exaluop;
  logic [TW-1:0] exdest;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  rs_alu #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .alloc_en(alloc_en), .alloc_op(alloc_op), .alloc_pc(alloc_pc), .alloc_dest(alloc_dest),
    .alloc_v1(alloc_v1), .alloc_v2(alloc_v2), .alloc_q1(alloc_q1), .alloc_q2(alloc_q2),
    .cdb0_en(cdb0_en), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_en(cdb1_en), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .full(full), .ex_alu_en(ex_alu_en), .exsrc1(exsrc1), .exsrc2(exsrc2),
    .expc(expc), .exaluop(exaluop), .exdest(exdest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every issue pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ex_alu_en === 1'b1) begin
      exp_t got;
      got = '{src1: exsrc1, src2: exsrc2, pc: expc, op: exaluop, dest: exdest};
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got %h expected no issue", got);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL issue_payload: got %h expected %h", got, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_en = 1'b0;
    cdb0_en  = 1'b0;
    cdb1_en  = 1'b0;
    clr      = 1'b0;
  endtask

  task automatic alloc(input logic [OW-1:0] op, input logic [AW-1:0] pc, input logic [TW-1:0] dest,
                       input logic [DW-1:0] v1, input logic [TW-1:0] q1,
                       input logic [DW-1:0] v2, input logic [TW-1:0] q2);
    alloc_en   = 1'b1;
    alloc_op   = op;
    alloc_pc   = pc;
    alloc_dest = dest;
    alloc_v1   = v1;
    alloc_q1   = q1;
    alloc_v2   = v2;
    alloc_q2   = q2;
  endtask

  task automatic push(input logic [DW-1:0] s1, input logic [DW-1:0] s2, input logic [AW-1:0] pc,
                      input logic [OW-1:0] op, input logic [TW-1:0] dest);
    sb_q.push_back('{src1: s1, src2: s2, pc: pc, op: op, dest: dest});
  endtask

  task automatic cdb0(input logic [TW-1:0] tag, input logic [DW-1:0] data);
    cdb0_en = 1'b1; cdb0_tag = tag; cdb0_data = data;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_en"},     64'(ex_alu_en), 64'(0));
    check({tag, "_full"},   64'(full),      64'(0));
    check({tag, "_src1"},   64'(exsrc1),    64'(0));
    check({tag, "_src2"},   64'(exsrc2),    64'(0));
    check({tag, "_pc"},     64'(expc),      64'(0));
    check({tag, "_op"},     64'(exaluop),   64'(0));
    check({tag, "_dest"},   64'(exdest),    64'(TF));
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    alloc_op = '0; alloc_pc = '0; alloc_dest = '0;
    alloc_v1 = '0; alloc_v2 = '0; alloc_q1 = TF; alloc_q2 = TF;
    cdb0_tag = '0; cdb0_data = '0; cdb1_tag = '0; cdb1_data = '0;
    #2;
    check_reset("por");
    tick(); tick();
    rst_n = 1'b1;

    // Ready dispatch: issues two edges after allocation, for one cycle.
    alloc(6'd1, 32'h1000, 5'd3, 32'd5, TF, 32'd7, TF);
    push(32'd5, 32'd7, 32'h1000, 6'd1, 5'd3);
    tick(); idle();
    check("ready_e0_en", 64'(ex_alu_en), 64'(0));
    tick();
    check("ready_e1_en", 64'(ex_alu_en), 64'(1));
    check("ready_src1",  64'(exsrc1),    64'(5));
    tick();
    check("ready_pulse_end", 64'(ex_alu_en), 64'(0));

    // Wakeup from cdb1.
    alloc(6'd2, 32'h1004, 5'd4, 32'd0, 5'd6, 32'd2, TF);
    tick(); idle(); tick(); tick();
    check("wake_wait_en", 64'(ex_alu_en), 64'(0));
    cdb1_en = 1'b1; cdb1_tag = 5'd6; cdb1_data = 32'h100;
    push(32'h100, 32'd2, 32'h1004, 6'd2, 5'd4);
    tick(); idle();
    check("wake_edge_en", 64'(ex_alu_en), 64'(0));
    tick();
    check("wake_issue_en", 64'(ex_alu_en), 64'(1));
    check("wake_src1",     64'(exsrc1),    64'(32'h100));

    // Allocation bypass from cdb0.
    alloc(6'd3, 32'h1008, 5'd5, 32'd11, TF, 32'd0, 5'd9);
    cdb0(5'd9, 32'hABCD);
    push(32'd11, 32'hABCD, 32'h1008, 6'd3, 5'd5);
    tick(); idle(); tick();
    check("byp_issue_en", 64'(ex_alu_en), 64'(1));
    check("byp_src2",     64'(exsrc2),    64'(32'hABCD));
    tick();

    // Fill, overflow ignored, drain in index order.
    for (int i = 0; i < 4; i++) begin
      alloc(6'd4, 32'h2000 + 32'(4 * i), 5'(10 + i), 32'd0, 5'd5, 32'h20 + 32'(i), TF);
      push(32'h55, 32'h20 + 32'(i), 32'h2000 + 32'(4 * i), 6'd4, 5'(10 + i));
      tick();
    end
    check("fill_full", 64'(full), 64'(1));
    alloc(6'd7, 32'h2100, 5'd20, 32'h999, TF, 32'h1, TF);
    tick(); idle();
    check("ovf_full", 64'(full),      64'(1));
    check("ovf_en",   64'(ex_alu_en), 64'(0));
    cdb0(5'd5, 32'h55);
    tick(); idle();
    check("drain_wake_full", 64'(full), 64'(1));
    tick();
    check("drain_first_en",   64'(ex_alu_en), 64'(1));
    check("drain_first_dest", 64'(exdest),    64'(10));
    check("drain_full_drop",  64'(full),      64'(0));
    tick(); tick(); tick(); tick();
    check("drain_done_en", 64'(ex_alu_en), 64'(0));

    // Issue from a full station and allocation on the same edge.
    alloc(6'd5, 32'h3000, 5'd16, 32'd0, 5'd7, 32'h40, TF);
    tick();
    for (int i = 1; i < 4; i++) begin
      alloc(6'd5, 32'h3000 + 32'(4 * i), 5'(16 + i), 32'd0, 5'd8, 32'h40 + 32'(i), TF);
      tick();
    end
    idle();
    check("sim_full", 64'(full), 64'(1));
    cdb0(5'd7, 32'h77);
    push(32'h77, 32'h40, 32'h3000, 6'd5, 5'd16);
    tick(); idle();
    check("sim_wake_en", 64'(ex_alu_en), 64'(0));
    alloc(6'd6, 32'h3100, 5'd25, 32'h21, TF, 32'h22, TF);
    tick(); idle();
    check("sim_issue_en",   64'(ex_alu_en), 64'(1));
    check("sim_issue_dest", 64'(exdest),    64'(16));
    check("sim_free",       64'(full),      64'(0));
    alloc(6'd6, 32'h3104, 5'd26, 32'h31, TF, 32'h32, TF);
    push(32'h31, 32'h32, 32'h3104, 6'd6, 5'd26);
    tick(); idle();
    check("sim_refill_full", 64'(full), 64'(1));
    tick();
    check("sim_refill_dest", 64'(exdest), 64'(26));
    cdb0(5'd8, 32'h88);
    for (int i = 1; i < 4; i++) push(32'h88, 32'h40 + 32'(i), 32'h3000 + 32'(4 * i), 6'd5, 5'(16 + i));
    tick(); idle();
    tick(); tick(); tick(); tick();
    check("sim_done_en", 64'(ex_alu_en), 64'(0));

    // Flush drops waiting entries; their wakeup must not issue anything.
    for (int i = 0; i < 3; i++) begin
      alloc(6'd8, 32'h4000 + 32'(4 * i), 5'(1 + i), 32'd0, 5'd12, 32'd0, TF);
      tick();
    end
    idle();
    check("flush_pre_full", 64'(full), 64'(0));
    clr = 1'b1;
    tick(); idle();
    check("flush_en", 64'(ex_alu_en), 64'(0));
    cdb0(5'd12, 32'h12);
    tick(); idle(); tick(); tick();
    check("flush_after_en", 64'(ex_alu_en), 64'(0));
    for (int i = 0; i < 4; i++) begin
      alloc(6'd9, 32'h5000 + 32'(4 * i), 5'(1 + i), 32'd0, 5'd13, 32'd0, 5'd14);
      tick();
    end
    idle();
    check("flush_refill_full", 64'(full), 64'(1));

    // Mid-cycle reset with partially woken entries.
    cdb0(5'd13, 32'h13);
    tick(); idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    cdb0(5'd14, 32'h14);
    tick(); idle(); tick(); tick();
    check("rst_no_issue_en", 64'(ex_alu_en), 64'(0));
    check("rst_empty_full",  64'(full),      64'(0));
    for (int i = 0; i < 4; i++) begin
      alloc(6'd10, 32'h6000 + 32'(4 * i), 5'(1 + i), 32'd0, 5'd15, 32'd0, TF);
      tick();
    end
    idle();
    check("rst_refill_full", 64'(full), 64'(1));
    clr = 1'b1;
    tick(); idle(); tick();
    check("end_full", 64'(full), 64'(0));
    check("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
